// File: rtl/rvga_mem_responder_pkg.sv
// Shared types for the rvga memory responder: data word, FSM state encoding
// and the captured request record.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        e_mem_idle,
        e_mem_wait,
        e_mem_resp
    } rvga_mem_state_e;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] addr;
        rvga_word    data;
    } rvga_mem_req_s;

endpackage

// File: rtl/rvga_sram_1rw.sv
// Single-port synchronous SRAM with registered read. A combined read/write
// access returns the word as it was before the write lands.
module rvga_sram_1rw #(
    parameter int width_p     = 32,
    parameter int els_p       = 1024,
    parameter     init_file_p = ""
) (
    input  logic                     clk,
    input  logic                     v,
    input  logic                     w,
    input  logic [$clog2(els_p)-1:0] addr,
    input  logic [width_p-1:0]       wdata,
    output logic [width_p-1:0]       rdata
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk) begin
        if (v) begin
            rdata <= mem[addr];
            if (w) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/rvga_mem_responder.sv
// Word-addressed memory answering one imem/dmem request at a time with a
// fixed, programmable response latency; backed by a single-port SRAM.
module rvga_mem_responder
    import rvga_types::*;
#(
    parameter int words_p     = 1024,
    parameter int latency_p   = 2,
    parameter     init_file_p = ""
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     r_v_i,
    input  logic     w_v_i,
    input  logic [31:0] addr_i,
    input  rvga_word data_i,
    output rvga_word data_o,
    output logic     resp_v_o,
    output logic     err_o
);

    localparam int idx_w_lp = $clog2(words_p);
    localparam int cnt_w_lp = (latency_p > 1) ? $clog2(latency_p) : 1;

    rvga_mem_state_e      state_q, state_n;
    logic [cnt_w_lp-1:0]  cnt_q;
    rvga_mem_req_s        req_q;

    logic                 req_v;
    logic                 in_oor, req_oor;
    logic                 sram_v, sram_w;
    logic [idx_w_lp-1:0]  sram_addr;
    rvga_word             sram_wdata, sram_rdata;
    logic                 unused;

    assign req_v   = r_v_i | w_v_i;
    assign in_oor  = |addr_i[31:idx_w_lp+2];
    assign req_oor = |req_q.addr[31:idx_w_lp+2];
    assign unused  = ^{addr_i[1:0], req_q.addr[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= e_mem_idle;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == e_mem_idle && req_v) begin
                req_q <= '{r: r_v_i, w: w_v_i, addr: addr_i, data: data_i};
                cnt_q <= cnt_w_lp'(latency_p - 1);
            end else if (state_q == e_mem_wait) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // The SRAM is touched in the cycle just before RESP so its registered
    // read lands exactly in RESP; with latency 1 that cycle is the capture cycle.
    always_comb begin
        state_n    = state_q;
        sram_v     = 1'b0;
        sram_w     = 1'b0;
        sram_addr  = req_q.addr[idx_w_lp+1:2];
        sram_wdata = req_q.data;
        resp_v_o   = 1'b0;
        err_o      = 1'b0;
        data_o     = '0;
        case (state_q)
            e_mem_idle: begin
                if (req_v) begin
                    if (latency_p == 1) begin
                        state_n    = e_mem_resp;
                        sram_v     = !in_oor;
                        sram_w     = w_v_i;
                        sram_addr  = addr_i[idx_w_lp+1:2];
                        sram_wdata = data_i;
                    end else begin
                        state_n = e_mem_wait;
                    end
                end
            end
            e_mem_wait: begin
                if (cnt_q == cnt_w_lp'(1)) begin
                    state_n = e_mem_resp;
                    sram_v  = !req_oor && (req_q.r || req_q.w);
                    sram_w  = req_q.w;
                end
            end
            e_mem_resp: begin
                state_n  = e_mem_idle;
                resp_v_o = 1'b1;
                err_o    = req_oor;
                data_o   = req_oor ? '0 : sram_rdata;
            end
            default: state_n = e_mem_idle;
        endcase
    end

    rvga_sram_1rw #(
        .width_p    (32),
        .els_p      (words_p),
        .init_file_p(init_file_p)
    ) sram (
        .clk  (clk_i),
        .v    (sram_v),
        .w    (sram_w),
        .addr (sram_addr),
        .wdata(sram_wdata),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_rvga_mem_responder.sv
// Randomized bench for rvga_mem_responder: a word-array reference model
// predicts every response, checked each cycle, plus literal directed checks.
module tb_rvga_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_v, w_v;
    logic [31:0] addr, wdata, rdata;
    logic        resp_v, err;

    logic        r_v1, w_v1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        resp_v1, err1;

    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    // reference model state
    logic [31:0] mem_m [16];
    int          exp_cyc = -1;
    logic        exp_err = 1'b0;
    logic [31:0] exp_data = '0;

    rvga_mem_responder #(.words_p(16), .latency_p(LAT), .init_file_p("")) dut (
        .clk_i(clk), .rst_i(rst), .r_v_i(r_v), .w_v_i(w_v), .addr_i(addr),
        .data_i(wdata), .data_o(rdata), .resp_v_o(resp_v), .err_o(err)
    );

    rvga_mem_responder #(.words_p(16), .latency_p(1), .init_file_p("")) dut1 (
        .clk_i(clk), .rst_i(rst), .r_v_i(r_v1), .w_v_i(w_v1), .addr_i(addr1),
        .data_i(wdata1), .data_o(rdata1), .resp_v_o(resp_v1), .err_o(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else passed++;
    endtask

    // Every cycle: outputs must match the model's single pending response.
    always @(negedge clk) begin
        logic ev;
        ev = (cyc == exp_cyc);
        chk("resp_v", {31'b0, resp_v}, {31'b0, ev});
        chk("err", {31'b0, err}, {31'b0, ev ? exp_err : 1'b0});
        chk("data", rdata, ev ? exp_data : 32'h0);
    end

    task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat, output int rc);
        int start;
        logic oor;
        @(posedge clk); #1;
        r_v = r; w_v = w; addr = a; wdata = d;
        start = cyc;
        oor = |a[31:6];
        exp_err  = oor;
        exp_data = oor ? 32'h0 : mem_m[a[5:2]];
        if (w && !oor) mem_m[a[5:2]] = d;
        exp_cyc = start + LAT;
        lat = -1; rc = -1; rd = 'x; er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_v) begin
                lat = cyc - start; rc = cyc; rd = rdata; er = err;
                break;
            end
        end
        if (lat < 0) chk("resp_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        r_v = 1'b0; w_v = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic abort_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        exp_cyc = -1;
        r_v = r; w_v = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rst = 1'b1; r_v = 1'b0; w_v = 1'b0;
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, rc, rc2, s1;
        logic [31:0] a;
        bit          r, w;

        rst = 1'b1;
        r_v = 0; w_v = 0; addr = 0; wdata = 0;
        r_v1 = 0; w_v1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_resp_v", {31'b0, resp_v}, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);
        chk("reset_data", rdata, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 16; i++) req(1'b0, 1'b1, i * 4, 32'h1000_0000 + i, rd, er, lat, rc);
        idle(2);

        // write then read back
        req(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, rd, er, lat, rc);
        chk("wr8_latency", lat, 3);
        idle(1);
        req(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, rc);
        chk("rd8_latency", lat, 3);
        chk("rd8_data", rd, 32'hDEADBEEF);
        idle(2);

        // out of range
        req(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat, rc);
        chk("oor_rd_latency", lat, 3);
        chk("oor_rd_data", rd, 32'h0);
        chk("oor_rd_err", {31'b0, er}, 32'h1);
        idle(1);
        req(1'b0, 1'b1, 32'h40, 32'h5, rd, er, lat, rc);
        chk("oor_wr_err", {31'b0, er}, 32'h1);
        idle(1);
        req(1'b1, 1'b0, 32'h0, 32'h0, rd, er, lat, rc);
        chk("rd0_unchanged", rd, 32'h1000_0000);
        idle(1);

        // read-before-write on a combined request
        req(1'b0, 1'b1, 32'h4, 32'h11, rd, er, lat, rc);
        idle(1);
        req(1'b1, 1'b1, 32'h4, 32'h22, rd, er, lat, rc);
        chk("rw_old_word", rd, 32'h11);
        idle(1);
        req(1'b1, 1'b0, 32'h4, 32'h0, rd, er, lat, rc);
        chk("rw_new_word", rd, 32'h22);
        idle(2);

        // reset aborts in WAIT: no response, no write
        abort_req(1'b1, 1'b0, 32'h0, 32'h0);
        req(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, rc);
        chk("post_abort_latency", lat, 3);
        idle(1);
        abort_req(1'b0, 1'b1, 32'hC, 32'hBAD0_BAD0);
        req(1'b1, 1'b0, 32'hC, 32'h0, rd, er, lat, rc);
        chk("aborted_write_dropped", rd, 32'h1000_0003);
        idle(2);

        // back-to-back reads
        req(1'b1, 1'b0, 32'h0, 32'h0, rd, er, lat, rc);
        s1 = rc - lat;
        req(1'b1, 1'b0, 32'h4, 32'h0, rd, er, lat, rc2);
        chk("b2b_first_resp", rc - s1, 3);
        chk("b2b_second_resp", rc2 - s1, 7);
        idle(2);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            if ($urandom_range(0, 7) == 0) a = $urandom | (32'h40 << $urandom_range(0, 25));
            else a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            req(r, w, a, $urandom, rd, er, lat, rc);
            chk("rand_latency", lat, 3);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(3);

        // latency 1 instance: back-to-back responses in cycles 1 and 3
        begin
            logic [31:0] a1 [4];
            logic [31:0] d1 [4];
            bit          wr1 [4];
            a1 = '{32'h0, 32'h4, 32'h0, 32'h4};
            d1 = '{32'hA0, 32'hB4, 32'h0, 32'h0};
            wr1 = '{1'b1, 1'b1, 1'b0, 1'b0};
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                r_v1 = !wr1[k]; w_v1 = wr1[k]; addr1 = a1[k]; wdata1 = d1[k];
                @(negedge clk);
                chk("lat1_cycle0_resp", {31'b0, resp_v1}, 32'h0);
                @(negedge clk);
                chk("lat1_cycle1_resp", {31'b0, resp_v1}, 32'h1);
                chk("lat1_err", {31'b0, err1}, 32'h0);
                if (k == 2) chk("lat1_rd0", rdata1, 32'hA0);
                if (k == 3) chk("lat1_rd4", rdata1, 32'hB4);
            end
            @(posedge clk); #1;
            r_v1 = 1'b0; w_v1 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("lat1_idle_resp", {31'b0, resp_v1}, 32'h0);
            chk("lat1_idle_data", rdata1, 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
